// File: rtl/rom_dbg_sequencer.sv
// Debug-port sequencer for the i4001 ROM bank: arbitrates a bulk loader (write + read-back
// verify) and a host single-access port, holding the CPU in reset while the port is driven.
module rom_dbg_sequencer #(
    parameter int unsigned NUM_ROMS      = 16,
    parameter int unsigned BYTES_PER_ROM = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        load_abort,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        load_done,
    output logic        load_aborted,
    output logic [7:0]  err_cnt,
    output logic [11:0] first_err_addr,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [11:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        host_err,
    output logic [11:0] dbg_addr,
    output logic [7:0]  dbg_wdata,
    output logic        dbg_wen,
    output logic        dbg_ren,
    input  logic [7:0]  dbg_rdata,
    output logic        cpu_rst,
    output logic        busy
);

    localparam logic [11:0] LastAddr = 12'(NUM_ROMS * BYTES_PER_ROM - 1);

    typedef enum logic [3:0] {
        StIdle, StLoadWr, StLoadRd, StLoadChk, StDone, StSWr, StSRd, StSCap, StAck
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [11:0] first_err_q, first_err_d;
    logic [11:0] h_addr_q, h_addr_d;
    logic [7:0]  h_wdata_q, h_wdata_d;
    logic        host_err_q, host_err_d;
    logic [7:0]  host_rdata_q, host_rdata_d;
    logic [11:0] dbg_addr_q;
    logic        in_load;
    logic        out_of_range;

    assign in_load      = (state_q == StLoadWr) || (state_q == StLoadRd) || (state_q == StLoadChk);
    assign out_of_range = 32'(host_addr[11:8]) >= NUM_ROMS;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        byte_d       = byte_q;
        err_cnt_d    = err_cnt_q;
        first_err_d  = first_err_q;
        h_addr_d     = h_addr_q;
        h_wdata_d    = h_wdata_q;
        host_err_d   = host_err_q;
        host_rdata_d = host_rdata_q;
        s_ready      = 1'b0;
        load_done    = 1'b0;
        load_aborted = 1'b0;
        host_ack     = 1'b0;
        dbg_wen      = 1'b0;
        dbg_ren      = 1'b0;
        dbg_wdata    = 8'h00;
        dbg_addr     = dbg_addr_q;

        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    addr_d      = 12'h000;
                    err_cnt_d   = 8'h00;
                    first_err_d = 12'h000;
                    state_d     = StLoadWr;
                end else if (host_req) begin
                    h_addr_d  = host_addr;
                    h_wdata_d = host_wdata;
                    if (out_of_range) begin
                        host_err_d   = 1'b1;
                        host_rdata_d = 8'h00;
                        state_d      = StAck;
                    end else begin
                        host_err_d = 1'b0;
                        state_d    = host_we ? StSWr : StSRd;
                    end
                end
            end
            StLoadWr: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    dbg_wen   = 1'b1;
                    dbg_addr  = addr_q;
                    dbg_wdata = s_data;
                    byte_d    = s_data;
                    state_d   = StLoadRd;
                end
            end
            StLoadRd: begin
                dbg_ren  = 1'b1;
                dbg_addr = addr_q;
                state_d  = StLoadChk;
            end
            StLoadChk: begin
                if (dbg_rdata != byte_q) begin
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    // A zero count means no mismatch yet, since the count never wraps.
                    if (err_cnt_q == 8'h00) first_err_d = addr_q;
                end
                if (addr_q == LastAddr) begin
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + 12'd1;
                    state_d = StLoadWr;
                end
            end
            StDone: begin
                load_done = 1'b1;
                state_d   = StIdle;
            end
            StSWr: begin
                dbg_wen   = 1'b1;
                dbg_addr  = h_addr_q;
                dbg_wdata = h_wdata_q;
                state_d   = StAck;
            end
            StSRd: begin
                dbg_ren  = 1'b1;
                dbg_addr = h_addr_q;
                state_d  = StSCap;
            end
            StSCap: begin
                host_rdata_d = dbg_rdata;
                state_d      = StAck;
            end
            StAck: begin
                host_ack = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over any in-flight verify; a write strobed this cycle still lands.
        if (in_load && load_abort) begin
            load_aborted = 1'b1;
            err_cnt_d    = err_cnt_q;
            first_err_d  = first_err_q;
            state_d      = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= 12'h000;
            byte_q       <= 8'h00;
            err_cnt_q    <= 8'h00;
            first_err_q  <= 12'h000;
            h_addr_q     <= 12'h000;
            h_wdata_q    <= 8'h00;
            host_err_q   <= 1'b0;
            host_rdata_q <= 8'h00;
            dbg_addr_q   <= 12'h000;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            byte_q       <= byte_d;
            err_cnt_q    <= err_cnt_d;
            first_err_q  <= first_err_d;
            h_addr_q     <= h_addr_d;
            h_wdata_q    <= h_wdata_d;
            host_err_q   <= host_err_d;
            host_rdata_q <= host_rdata_d;
            dbg_addr_q   <= dbg_addr;
        end
    end

    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;
    assign host_rdata     = host_rdata_q;
    assign host_err       = host_ack & host_err_q;
    assign busy           = state_q != StIdle;
    assign cpu_rst        = rst | busy;

endmodule
